// File: rtl/video_mode_sched.sv
// Display-mode scheduler: advances the active video mode only at frame boundaries,
// either automatically every FRAME_HOLD frames or on a latched manual request.
`timescale 1ns/1ps

module video_mode_sched #(
    parameter int MODE_NUM   = 4,
    parameter int FRAME_HOLD = 60,
    parameter bit VS_POL     = 1'b1
) (
    input  logic        pix_clk,
    input  logic        rstn,
    input  logic        vs_in,
    input  logic        auto_en,
    input  logic        next_req,
    output logic [2:0]  mode_out,
    output logic        mode_chg,
    output logic        frame_start,
    output logic [15:0] frame_cnt,
    output logic        req_pending
);

    typedef enum logic [1:0] {
        SYNC,
        RUN,
        ARMED
    } state_t;

    localparam logic [2:0]  MODE_LAST = 3'(MODE_NUM - 1);
    localparam logic [15:0] HOLD_LAST = 16'(FRAME_HOLD - 1);
    localparam logic        VS_IDLE   = ~VS_POL;

    state_t      state;
    state_t      state_next;
    logic        pend_flag;
    logic        pend_next;
    logic        vs_d;
    logic        vs_edge;
    logic        auto_hit;
    logic        advance;
    logic [15:0] hold_cnt;

    assign vs_edge  = (vs_in == VS_POL) && (vs_d != VS_POL);
    assign auto_hit = auto_en && (hold_cnt == HOLD_LAST);

    // pend_flag only matters in SYNC; RUN/ARMED carry the request in the state itself.
    assign req_pending = (state == ARMED) || ((state == SYNC) && pend_flag);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        pend_next  = pend_flag;
        advance    = 1'b0;
        case (state)
            SYNC: begin
                // First boundary only aligns to the frame; it never moves the mode.
                if (vs_edge) begin
                    state_next = (pend_flag || next_req) ? ARMED : RUN;
                    pend_next  = 1'b0;
                end else if (next_req) begin
                    pend_next = 1'b1;
                end
            end
            RUN: begin
                if (vs_edge) begin
                    advance = auto_hit;
                end
                if (next_req) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                // A request arriving on the boundary itself is kept for the next one.
                if (vs_edge) begin
                    advance    = 1'b1;
                    state_next = next_req ? ARMED : RUN;
                end
            end
            default: begin
                state_next = SYNC;
                pend_next  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            state     <= SYNC;
            pend_flag <= 1'b0;
        end else begin
            state     <= state_next;
            pend_flag <= pend_next;
        end
    end

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            vs_d        <= VS_IDLE;
            frame_start <= 1'b0;
            frame_cnt   <= 16'd0;
            mode_out    <= 3'd0;
            mode_chg    <= 1'b0;
            hold_cnt    <= 16'd0;
        end else begin
            vs_d        <= vs_in;
            frame_start <= vs_edge;
            mode_chg    <= advance;
            if (vs_edge) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (advance) begin
                mode_out <= (mode_out == MODE_LAST) ? 3'd0 : mode_out + 3'd1;
            end
            if (!auto_en || (state == SYNC)) begin
                hold_cnt <= 16'd0;
            end else if (vs_edge) begin
                hold_cnt <= advance ? 16'd0 : hold_cnt + 16'd1;
            end
        end
    end

endmodule
